operacje_bitowe_potok: RTL and testbench

Pipelined, parametrised bit-field manipulation unit for the synchronous arithmetic unit: set, clear, toggle or extract a field of 1..BITS bits in operand A, at the position given by operand B. It replaces the single-bit combinational set operation with a two-stage registered datapath. The datapath has valid/ready handshakes on both sides, a per-result error flag and a saturating error counter.

---
 rtl/operacje_bitowe_pkg.sv | 25 ++
 rtl/operacje_bitowe_potok_generator_maski.sv | 35 +++
 rtl/operacje_bitowe_potok.sv | 130 +++++++++++++
 tb/tb_operacje_bitowe_potok.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/operacje_bitowe_pkg.sv
// Shared types for the pipelined bit-field manipulation unit.
package operacje_bitowe_pkg;

  typedef enum logic [1:0] {
    OP_SET = 2'd0,
    OP_CLR = 2'd1,
    OP_TGL = 2'd2,
    OP_EXT = 2'd3
  } op_e;

  // Fixed-width view of a stage-1 entry at the default 32-bit operand width.
  // The top module builds its own struct with the same field order so that the
  // operand width stays a module parameter.
  localparam int DEF_BITS  = 32;
  localparam int DEF_IDX_W = $clog2(DEF_BITS);

  typedef struct packed {
    op_e                  op;
    logic [DEF_BITS-1:0]  a;
    logic [DEF_IDX_W-1:0] idx;
    logic [DEF_BITS-1:0]  mask;
    logic                 err;
  } stage1_def_t;

endpackage

// File: rtl/operacje_bitowe_potok_generator_maski.sv
// Combinational field-mask generator: ones at bits start..start+n-1, plus an
// error flag when the field is negative or runs past the top of the word.
module generator_maski #(
  parameter int BITS  = 32,
  parameter int IDX_W = $clog2(BITS)
) (
  input  logic signed [BITS-1:0] start,
  input  logic [IDX_W:0]         n,
  output logic [BITS-1:0]        mask,
  output logic                   err
);

  // Two spare bits so start_low + n can never wrap.
  localparam int SUM_W = IDX_W + 2;
  localparam logic [SUM_W-1:0] LIMIT = SUM_W'(BITS);

  logic [SUM_W-1:0] start_low;
  logic [SUM_W-1:0] end_pos;
  logic             high_bits;

  assign start_low = {2'b00, start[IDX_W-1:0]};
  assign end_pos   = start_low + {1'b0, n};
  // Any set bit above the index range (below the sign) means start >= BITS.
  assign high_bits = |start[BITS-2:IDX_W];
  assign err       = start[BITS-1] | high_bits | (end_pos > LIMIT);

  genvar gi;
  generate
    for (gi = 0; gi < BITS; gi = gi + 1) begin : g_mask
      localparam logic [SUM_W-1:0] POS = SUM_W'(gi);
      assign mask[gi] = (POS >= start_low) && (POS < end_pos);
    end
  endgenerate

endmodule

// File: rtl/operacje_bitowe_potok.sv
// Two-stage pipelined set/clear/toggle/extract of a bit field, with
// valid/ready on both sides and a saturating count of errored results.
module operacje_bitowe_potok
  import operacje_bitowe_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int IDX_W = $clog2(BITS),
  parameter int CNT_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [1:0]             i_op,
  input  logic signed [BITS-1:0] i_arg_A,
  input  logic signed [BITS-1:0] i_arg_B,
  input  logic [IDX_W-1:0]       i_len,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic signed [BITS-1:0] o_result,
  output logic                   o_error,
  output logic [CNT_W-1:0]       o_err_cnt
);

  typedef struct packed {
    op_e              op;
    logic [BITS-1:0]  a;
    logic [IDX_W-1:0] idx;
    logic [BITS-1:0]  mask;
    logic             err;
  } stage1_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stage1_t          s1_reg;
  stage1_t          s1_next;
  logic             s1_valid_reg;
  logic             o_valid_reg;
  logic [BITS-1:0]  o_result_reg;
  logic             o_error_reg;
  logic [CNT_W-1:0] err_cnt_reg;

  logic             s2_load;
  logic             s1_load;
  logic             accept;
  logic [IDX_W:0]   field_n;
  logic [BITS-1:0]  gen_mask;
  logic             gen_err;
  logic [BITS-1:0]  result_next;

  // Handshake: stage 2 frees when its result leaves, stage 1 when it moves on.
  assign s2_load = !o_valid_reg || i_ready;
  assign s1_load = !s1_valid_reg || s2_load;
  assign o_ready = s1_load;
  assign accept  = i_valid && s1_load;

  assign field_n = {1'b0, i_len} + {{IDX_W{1'b0}}, 1'b1};

  generator_maski #(
    .BITS  (BITS),
    .IDX_W (IDX_W)
  ) u_generator_maski (
    .start (i_arg_B),
    .n     (field_n),
    .mask  (gen_mask),
    .err   (gen_err)
  );

  always_comb begin
    s1_next      = s1_reg;
    s1_next.op   = op_e'(i_op);
    s1_next.a    = i_arg_A;
    s1_next.idx  = i_arg_B[IDX_W-1:0];
    s1_next.mask = gen_mask;
    s1_next.err  = gen_err;
  end

  always_comb begin
    result_next = '0;
    if (!s1_reg.err) begin
      case (s1_reg.op)
        OP_SET:  result_next = s1_reg.a | s1_reg.mask;
        OP_CLR:  result_next = s1_reg.a & ~s1_reg.mask;
        OP_TGL:  result_next = s1_reg.a ^ s1_reg.mask;
        default: result_next = (s1_reg.a & s1_reg.mask) >> s1_reg.idx;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_reg <= 1'b0;
      s1_reg       <= '0;
    end else if (s1_load) begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_reg <= s1_next;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid_reg  <= 1'b0;
      o_result_reg <= '0;
      o_error_reg  <= 1'b0;
    end else if (s2_load) begin
      o_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        o_result_reg <= result_next;
        o_error_reg  <= s1_reg.err;
      end
    end
  end

  // Counted on delivery, not on acceptance, so flushed requests never count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_cnt_reg <= '0;
    end else if (o_valid_reg && i_ready && o_error_reg && (err_cnt_reg != CNT_MAX)) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign o_valid   = o_valid_reg;
  assign o_result  = o_result_reg;
  assign o_error   = o_error_reg;
  assign o_err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_operacje_bitowe_potok.sv
// Scoreboard bench: the driver queues hand-computed results on acceptance,
// the monitor pops and compares on every delivered result.
module tb_operacje_bitowe_potok;
  import operacje_bitowe_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [1:0]  i_op = 2'd0;
  logic [31:0] i_arg_A = '0;
  logic [31:0] i_arg_B = '0;
  logic [4:0]  i_len = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_result;
  logic        o_error;
  logic [1:0]  o_err_cnt;

  always #5 clk = ~clk;

  operacje_bitowe_potok #(
    .BITS  (32),
    .IDX_W (5),
    .CNT_W (2)
  ) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_op      (i_op),
    .i_arg_A   (i_arg_A),
    .i_arg_B   (i_arg_B),
    .i_len     (i_len),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_result  (o_result),
    .o_error   (o_error),
    .o_err_cnt (o_err_cnt)
  );

  typedef struct {
    logic [31:0] res;
    logic        err;
  } exp_t;

  typedef struct {
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  len;
    logic [31:0] res;
    logic        err;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_cnt = 0;
  int   n_deliv = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: a result leaves on the next rising edge when o_valid && i_ready.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!i_rst) begin
      if (o_valid && !i_ready && exp_q.size() != 0) begin
        check("stall_result", o_result, exp_q[0].res);
      end
      if (o_valid && i_ready) begin
        n_deliv++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=0x%08h required=none", o_result);
        end else begin
          e = exp_q.pop_front();
          check("result", o_result, e.res);
          check("error", 32'(o_error), 32'(e.err));
          check("err_cnt", 32'(o_err_cnt), 32'(exp_cnt));
          if (e.err && exp_cnt < 3) exp_cnt++;
          $display("deliver result=0x%08h err=%0d cnt=%0d", o_result, o_error, o_err_cnt);
        end
      end
    end
  end

  task automatic send(input vec_t v);
    int w = 0;
    @(negedge clk);
    i_valid = 1'b1;
    i_op    = v.op;
    i_arg_A = v.a;
    i_arg_B = v.b;
    i_len   = v.len;
    #1;
    while (!o_ready && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!o_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 required=1");
    end else begin
      exp_q.push_back('{res: v.res, err: v.err});
      $display("issue op=%0d a=0x%08h b=0x%08h len=%0d exp=0x%08h err=%0d",
               v.op, v.a, v.b, v.len, v.res, v.err);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  vec_t err_vecs[7] = '{
    '{OP_SET, 32'h0000_0000, 32'd29,        5'd3,  32'h0, 1'b1},
    '{OP_SET, 32'h0000_0000, 32'hFFFF_FFFF, 5'd0,  32'h0, 1'b1},
    '{OP_CLR, 32'hFFFF_FFFF, 32'h8000_0000, 5'd0,  32'h0, 1'b1},
    '{OP_TGL, 32'h1234_5678, 32'd40,        5'd0,  32'h0, 1'b1},
    '{OP_EXT, 32'h1234_5678, 32'd32,        5'd0,  32'h0, 1'b1},
    '{OP_SET, 32'h0000_0000, 32'd1,         5'd0,  32'h0000_0002, 1'b0},
    '{OP_TGL, 32'h0000_0000, 32'd0,         5'd3,  32'h0000_000F, 1'b0}
  };

  vec_t dir_vecs[14] = '{
    '{OP_SET, 32'h0000_0000, 32'd5,         5'd0,  32'h0000_0020, 1'b0},
    '{OP_CLR, 32'hFFFF_FFFF, 32'd4,         5'd7,  32'hFFFF_F00F, 1'b0},
    '{OP_TGL, 32'h0000_00F0, 32'd4,         5'd7,  32'h0000_0F00, 1'b0},
    '{OP_EXT, 32'h1234_5678, 32'd8,         5'd7,  32'h0000_0056, 1'b0},
    '{OP_SET, 32'h0000_0000, 32'd28,        5'd3,  32'hF000_0000, 1'b0},
    '{OP_SET, 32'h0000_0000, 32'd29,        5'd3,  32'h0000_0000, 1'b1},
    '{OP_SET, 32'h0000_0000, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 1'b1},
    '{OP_SET, 32'h0000_0000, 32'h8000_0000, 5'd0,  32'h0000_0000, 1'b1},
    '{OP_SET, 32'h0000_0000, 32'd0,         5'd31, 32'hFFFF_FFFF, 1'b0},
    '{OP_EXT, 32'h8000_0000, 32'd31,        5'd0,  32'h0000_0001, 1'b0},
    '{OP_CLR, 32'hA5A5_A5A5, 32'd0,         5'd31, 32'h0000_0000, 1'b0},
    '{OP_TGL, 32'hA5A5_A5A5, 32'd16,        5'd15, 32'h5A5A_A5A5, 1'b0},
    '{OP_SET, 32'h0000_0000, 32'd31,        5'd0,  32'h8000_0000, 1'b0},
    '{OP_EXT, 32'hFFFF_FFFF, 32'd32,        5'd0,  32'h0000_0000, 1'b1}
  };

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int w;

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_result", o_result, 32'd0);
    check("rst_o_error", 32'(o_error), 32'd0);
    check("rst_err_cnt", 32'(o_err_cnt), 32'd0);
    i_rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_o_ready", 32'(o_ready), 32'd1);

    // Two-cycle latency with i_ready held high.
    send('{OP_SET, 32'h0, 32'd5, 5'd0, 32'h0000_0020, 1'b0});
    @(negedge clk);
    #1;
    check("latency_cycle1", 32'(o_valid), 32'd0);
    @(negedge clk);
    #1;
    check("latency_cycle2", 32'(o_valid), 32'd1);
    drain();

    // Saturating error counter, then legal traffic leaves it at 3.
    foreach (err_vecs[i]) send(err_vecs[i]);
    drain();
    check("cnt_saturated", 32'(o_err_cnt), 32'd3);

    // Reset with two requests held in the pipe.
    i_ready = 1'b0;
    send('{OP_SET, 32'h0, 32'd7, 5'd0, 32'h0000_0080, 1'b0});
    send('{OP_SET, 32'h0, 32'd8, 5'd0, 32'h0000_0100, 1'b0});
    @(negedge clk);
    i_rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_o_valid", 32'(o_valid), 32'd0);
    check("midrst_err_cnt", 32'(o_err_cnt), 32'd0);
    i_rst   = 1'b0;
    exp_cnt = 0;
    i_ready = 1'b1;
    base    = n_deliv;
    @(negedge clk);
    #1;
    check("midrst_o_ready", 32'(o_ready), 32'd1);
    repeat (6) @(negedge clk);
    check("midrst_no_output", 32'(n_deliv - base), 32'd0);

    // Directed vectors back-to-back.
    foreach (dir_vecs[i]) send(dir_vecs[i]);
    drain();

    // Backpressure: i_ready low for 3 cycles from the first o_valid.
    base = n_deliv;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          send('{OP_SET, 32'h0, 32'(k), 5'd0, 32'd1 << k, 1'b0});
        end
      end
      begin
        w = 0;
        @(negedge clk);
        while (!o_valid && w < 20) begin
          @(negedge clk);
          w++;
        end
        check("bp_first_valid", 32'(o_valid), 32'd1);
        i_ready = 1'b0;
        #1;
        check("bp_ready_low", 32'(o_ready), 32'd0);
        repeat (3) @(negedge clk);
        i_ready = 1'b1;
      end
    join
    drain();
    check("bp_delivered", 32'(n_deliv - base), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
